// File: rtl/program_counter_if.sv
// Fetch-stage PC bus: core control and the branch unit drive the next-PC selection.
// The program counter drives back the current fetch address.
interface program_counter_if;
    logic [31:0] nextPC;
    logic [1:0]  nextPCop;
    logic        intVec;
    logic [31:0] PC;

    modport master (output nextPC, output nextPCop, output intVec, input PC);
    modport slave  (input nextPC, input nextPCop, input intVec, output PC);
endinterface

// File: rtl/program_counter.sv
// 32-bit RISC-V fetch program counter: hold, increment, load target, soft reset or interrupt redirect.
// PC is a pure register; an asynchronous rst returns it to the reset vector.
module program_counter #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] INT_VECTOR   = 32'h0000_0010,
    parameter logic [31:0] PC_INC       = 32'd4
) (
    input  logic                  clk,
    input  logic                  rst,
    program_counter_if.slave      bus
);

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_RVEC = 2'b11;

    logic [31:0] pc_r;
    logic [31:0] pc_next_s;

    // Forces the low two bits to zero so the fetch address stays word-aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Next-PC selection; the interrupt strobe overrides the op, unknown ops hold.
    always_comb begin
        pc_next_s = pc_r;
        if (bus.intVec == 1'b1) begin
            pc_next_s = word_align(INT_VECTOR);
        end else begin
            case (bus.nextPCop)
                OP_HOLD: pc_next_s = pc_r;
                OP_INC:  pc_next_s = word_align(pc_r + PC_INC);
                OP_LOAD: pc_next_s = word_align(bus.nextPC);
                OP_RVEC: pc_next_s = word_align(RESET_VECTOR);
                default: pc_next_s = pc_r;
            endcase
        end
    end

    // PC register with asynchronous return to the reset vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r <= word_align(RESET_VECTOR);
        end else begin
            pc_r <= pc_next_s;
        end
    end

    assign bus.PC = pc_r;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed scenarios plus randomized traffic
// compared every cycle against a behavioural next-PC model.
module tb_program_counter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_pc;

    program_counter_if bus ();

    program_counter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference behaviour: plain modular arithmetic on the architectural PC.
    function automatic logic [31:0] predict(input logic [31:0] pc, input logic [1:0] op,
                                            input logic [31:0] nv, input logic iv);
        logic [63:0] wide;
        if (iv) return 32'h0000_0010;
        case (op)
            2'd0: return pc;
            2'd1: begin
                wide = (64'(pc) + 64'd4) % 64'h1_0000_0000;
                return wide[31:0];
            end
            2'd2: return nv - (nv % 32'd4);
            default: return 32'h0000_0000;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) exp_pc <= 32'h0000_0000;
        else     exp_pc <= predict(exp_pc, bus.nextPCop, bus.nextPC, bus.intVec);
    end

    always @(negedge clk) begin
        checks = checks + 1;
        if (bus.PC !== exp_pc) begin
            errors = errors + 1;
            $display("FAIL model_cmp t=%0t PC=%h expected=%h", $time, bus.PC, exp_pc);
        end
    end

    task automatic pin(input string name, input logic [31:0] want);
        checks = checks + 1;
        if (bus.PC !== want) begin
            errors = errors + 1;
            $display("FAIL %s PC=%h expected=%h", name, bus.PC, want);
        end
    endtask

    task automatic step(input logic [1:0] op, input logic [31:0] nv, input logic iv);
        bus.nextPCop = op;
        bus.nextPC   = nv;
        bus.intVec   = iv;
        @(posedge clk);
        #2;
    endtask

    initial begin
        bus.nextPCop = 2'b00;
        bus.nextPC   = 32'h0;
        bus.intVec   = 1'b0;
        #1;
        pin("reset_value", 32'h0000_0000);
        @(posedge clk);
        #2;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) step(2'b11, 32'h8888_8888, 1'b0);
        pin("soft_reset_hold", 32'h0000_0000);

        for (int i = 0; i < 10; i++) step(2'b01, 32'h0, 1'b0);
        pin("inc_x10", 32'h0000_0028);
        step(2'b10, 32'hFFFF_FFFC, 1'b0);
        pin("load_top", 32'hFFFF_FFFC);
        step(2'b01, 32'h0, 1'b0);
        pin("inc_wrap", 32'h0000_0000);

        step(2'b10, 32'h8888_8888, 1'b0);
        pin("load_target", 32'h8888_8888);
        step(2'b10, 32'h8888_8889, 1'b0);
        pin("load_unaligned", 32'h8888_8888);

        for (int i = 0; i < 10; i++) step(2'b00, 32'h1234_5678, 1'b0);
        pin("hold_x10", 32'h8888_8888);

        step(2'b10, 32'h0000_0100, 1'b0);
        step(2'b01, 32'h0, 1'b1);
        pin("int_redirect", 32'h0000_0010);
        step(2'b01, 32'h0, 1'b0);
        pin("after_int", 32'h0000_0014);

        step(2'b10, 32'h0000_0040, 1'b0);
        pin("pre_async_rst", 32'h0000_0040);
        rst = 1'b1;
        #1;
        pin("async_rst_immediate", 32'h0000_0000);
        for (int i = 0; i < 3; i++) begin
            step(2'b10, 32'hDEAD_BEEC, 1'b1);
            pin("rst_held", 32'h0000_0000);
        end
        rst = 1'b0;
        step(2'b01, 32'h0, 1'b0);
        pin("first_after_rst", 32'h0000_0004);

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                rst = 1'b1;
                step(2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)));
                rst = 1'b0;
            end else begin
                step(2'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 7) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
